mem_access_unit: RTL and testbench

- RV32I load/store unit for the MEM stage. It sits between the EX/MEM pipeline register and the 32-word data memory, and drives the memory's rw_enable, address and wr_data directly.
- The data memory is word-only with a registered read, so this block splits each request into read / capture / write phases.
- It performs SB/SH stores as read-modify-write, sign- or zero-extends LB/LH/LBU/LHU results, and stalls the pipeline while busy.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 53 +++++
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 tb/tb_mem_access_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, state encoding and memory geometry for the load/store unit
package lsu_pkg;

  localparam int DMEM_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CAPT  = 2'd2,
    ST_WRITE = 2'd3
  } lsu_state_t;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane extract/extend for loads, lane merge for stores, alignment check
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_data,
  output logic            err
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] lane_mask;
  logic            is_unsigned;

  always_comb begin
    shamt       = {offset, 3'b000};
    shifted     = rdata >> shamt;
    is_unsigned = funct3[2];
    size_mask   = '1;
    load_data   = rdata;

    // funct3[1:0] is the access size for both loads and stores
    case (funct3[1:0])
      2'b00: begin
        size_mask = XLEN'(8'hFF);
        load_data = {{(XLEN-8){shifted[7] & ~is_unsigned}}, shifted[7:0]};
      end
      2'b01: begin
        size_mask = XLEN'(16'hFFFF);
        load_data = {{(XLEN-16){shifted[15] & ~is_unsigned}}, shifted[15:0]};
      end
      default: begin
        size_mask = '1;
        load_data = rdata;
      end
    endcase

    lane_mask  = size_mask << shamt;
    store_data = (rdata & ~lane_mask) | ((wdata << shamt) & lane_mask);

    err = f3_illegal(funct3)
        | ((funct3[1:0] == 2'b01) & offset[0])
        | ((funct3[1:0] == 2'b10) & (|offset));
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store FSM driving a word-only, registered-read data memory
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rw_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [XLEN-1:0]   mem_wr_data,
  input  logic [XLEN-1:0]   mem_re_data
);

  lsu_state_t state_q, state_d;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   merge_q;

  logic              latch_en, merge_en;
  logic              rsp_valid_d, rsp_err_d;
  logic [XLEN-1:0]   rsp_rdata_d;

  logic [2:0]        al_funct3;
  logic [1:0]        al_offset;
  logic [XLEN-1:0]   al_load, al_store;
  logic              al_err;

  // upper address bits alias onto the 32-word memory
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_W+2];

  // in IDLE the checker looks at the live request, afterwards at the latched one
  assign al_funct3 = (state_q == ST_IDLE) ? req_funct3    : funct3_q;
  assign al_offset = (state_q == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (al_funct3),
    .offset     (al_offset),
    .rdata      (mem_re_data),
    .wdata      (wdata_q),
    .load_data  (al_load),
    .store_data (al_store),
    .err        (al_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    latch_en      = 1'b0;
    merge_en      = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = '0;
    mem_rw_enable = 1'b0;
    mem_address   = '0;
    mem_wr_data   = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          latch_en = 1'b1;
          if (al_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we && (req_funct3 == F3_LW)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        mem_address = addr_q[ADDR_W+1:2];
        state_d     = ST_CAPT;
      end
      ST_CAPT: begin
        if (we_q) begin
          merge_en = 1'b1;
          state_d  = ST_WRITE;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = al_load;
          state_d     = ST_IDLE;
        end
      end
      ST_WRITE: begin
        mem_rw_enable = 1'b1;
        mem_address   = addr_q[ADDR_W+1:2];
        mem_wr_data   = (funct3_q == F3_LW) ? wdata_q : merge_q;
        rsp_valid_d   = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      merge_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (latch_en) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[ADDR_W+1:0];
        wdata_q  <= req_wdata;
      end
      if (merge_en) merge_q <= al_store;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural data memory
module tb_mem_access_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_rw_enable;
  logic [4:0]  mem_address;
  logic [31:0] mem_wr_data, mem_re_data;

  logic [31:0] dmem    [32];
  logic [31:0] ref_mem [32];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks   = 0;
  int failures = 0;

  mem_access_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_rw_enable (mem_rw_enable),
    .mem_address   (mem_address),
    .mem_wr_data   (mem_wr_data),
    .mem_re_data   (mem_re_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rw_enable) dmem[mem_address] <= mem_wr_data;
    mem_re_data <= dmem[mem_address];
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected rdata=%h err=%b required=no response", rsp_rdata, rsp_err);
      end else begin
        mon_e = sb_q.pop_front();
        if ({rsp_rdata, rsp_err} !== {mon_e.rdata, mon_e.err}) begin
          failures++;
          $display("FAIL rsp_data got rdata=%h err=%b required rdata=%h err=%b",
                   rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic model_err(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: return 1'b0;
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return off != 2'b00;
      default:       return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LBU:  return {24'h0, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LHU:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w, input logic [31:0] wd);
    logic [31:0] r;
    r = w;
    if (f3[1:0] == 2'b00) begin
      case (off)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (f3[1:0] == 2'b01) begin
      if (off[1]) r[31:16] = wd[15:0];
      else        r[15:0]  = wd[15:0];
    end else begin
      r = wd;
    end
    return r;
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge of the response cycle.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input string name);
    int          lat, exp_lat, wr_n, wr_k;
    logic [4:0]  idx, wa;
    logic [31:0] wd, exp_wd;
    logic        err;
    exp_t        e;
    idx     = addr[6:2];
    err     = model_err(f3, addr[1:0]);
    exp_lat = err ? 1 : (we ? ((f3 == F3_LW) ? 2 : 4) : 3);
    e.err   = err;
    e.rdata = (err || we) ? 32'h0 : model_load(f3, addr[1:0], ref_mem[idx]);
    exp_wd  = (f3 == F3_LW) ? wdata : model_store(f3, addr[1:0], ref_mem[idx], wdata);
    wa = '0; wd = '0;

    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_at_issue got=%b required=1", name, req_ready);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    sb_q.push_back(e);
    @(posedge clk);

    lat = 0; wr_n = 0; wr_k = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_rw_enable === 1'b1) begin
        wr_n++; wr_k = k; wa = mem_address; wd = mem_wr_data;
      end
      if (rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
      checks++;
      if (req_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy_ready cycle=T+%0d got=%b required=0", name, k, req_ready);
      end
    end

    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d required=%0d (0 = no response)", name, lat, exp_lat);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_in_rsp got=%b required=1", name, req_ready);
    end
    checks++;
    if (we && !err) begin
      if (wr_n != 1 || wr_k != exp_lat - 1 || wa !== idx || wd !== exp_wd) begin
        failures++;
        $display("FAIL %s_write got n=%0d at=T+%0d addr=%0d data=%h required n=1 at=T+%0d addr=%0d data=%h",
                 name, wr_n, wr_k, wa, wd, exp_lat - 1, idx, exp_wd);
      end
      ref_mem[idx] = exp_wd;
    end else if (wr_n != 0) begin
      failures++;
      $display("FAIL %s_no_write got n=%0d required=0", name, wr_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
      failures++;
      $display("FAIL reset_rsp got valid=%b err=%b rdata=%h required all 0", rsp_valid, rsp_err, rsp_rdata);
    end
    checks++;
    if ({mem_rw_enable, mem_address, mem_wr_data} !== 38'h0) begin
      failures++;
      $display("FAIL reset_mem got rw=%b addr=%0d wdata=%h required all 0", mem_rw_enable, mem_address, mem_wr_data);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b required=1", req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads_stores();
    run_req(1'b0, F3_LW, 32'h14, 32'h0, "lw_0x14");
    run_req(1'b1, 3'b000, 32'h09, 32'h000000AB, "sb_0x09");
    checks++;
    if (dmem[2] !== 32'h0000AB02) begin
      failures++;
      $display("FAIL sb_word2 got=%h required=0000ab02", dmem[2]);
    end
    run_req(1'b0, F3_LW,  32'h08, 32'h0, "lw_0x08");
    run_req(1'b0, F3_LB,  32'h09, 32'h0, "lb_0x09");
    run_req(1'b0, F3_LBU, 32'h09, 32'h0, "lbu_0x09");
  endtask

  task automatic test_halfwords();
    run_req(1'b1, 3'b001, 32'h0E, 32'h12348001, "sh_0x0e");
    checks++;
    if (dmem[3] !== 32'h80010003) begin
      failures++;
      $display("FAIL sh_word3 got=%h required=80010003", dmem[3]);
    end
    run_req(1'b0, F3_LH,  32'h0E, 32'h0, "lh_0x0e");
    run_req(1'b0, F3_LHU, 32'h0E, 32'h0, "lhu_0x0e");
    run_req(1'b0, F3_LH,  32'h0C, 32'h0, "lh_0x0c");
    for (int o = 0; o < 4; o++) begin
      run_req(1'b0, F3_LB, 32'h0C + o, 32'h0, "lb_lane");
    end
  endtask

  task automatic test_errors();
    run_req(1'b0, F3_LW,  32'h06, 32'h0, "err_lw_0x06");
    run_req(1'b1, 3'b001, 32'h03, 32'hFFFF, "err_sh_0x03");
    run_req(1'b0, 3'b011, 32'h10, 32'h0, "err_f3_011");
    run_req(1'b1, 3'b110, 32'h10, 32'h5555, "err_st_110");
    run_req(1'b0, F3_LHU, 32'h11, 32'h0, "err_lhu_0x11");
  endtask

  task automatic test_back_to_back();
    run_req(1'b1, F3_LW, 32'h7C, 32'hDEADBEEF, "sw_0x7c");
    run_req(1'b1, F3_LW, 32'h80, 32'hCAFEF00D, "sw_alias_0x80");
    run_req(1'b0, F3_LW, 32'h00, 32'h0, "lw_0x00");
    run_req(1'b0, F3_LW, 32'h7C, 32'h0, "lw_0x7c");
    run_req(1'b1, 3'b000, 32'h7F, 32'h00000080, "sb_0x7f");
    run_req(1'b0, F3_LB, 32'h7F, 32'h0, "lb_0x7f");
    run_req(1'b0, F3_LW, 32'h02, 32'h0, "err_then");
    run_req(1'b0, F3_LHU, 32'h7E, 32'h0, "lhu_0x7e");
  endtask

  task automatic test_reset_mid();
    // reset during CAPT of an SB to word 1
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h04; req_wdata = 32'hCC;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    checks++;
    if (req_ready !== 1'b1 || mem_rw_enable !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_capt_idle got ready=%b rw=%b rsp=%b required 1/0/0", req_ready, mem_rw_enable, rsp_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dmem[1] !== 32'h00000001) begin
      failures++;
      $display("FAIL rst_capt_word1 got=%h required=00000001", dmem[1]);
    end

    // reset during WRITE of an SB to word 1: write still lands
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h04; req_wdata = 32'h5A;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_rw_enable !== 1'b1 || mem_address !== 5'd1 || mem_wr_data !== 32'h0000005A) begin
      failures++;
      $display("FAIL rst_write_cycle got rw=%b addr=%0d data=%h required 1/1/0000005a",
               mem_rw_enable, mem_address, mem_wr_data);
    end
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    ref_mem[1] = 32'h0000005A;
    checks++;
    if (dmem[1] !== 32'h0000005A || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_write_commit got word1=%h rsp=%b required 0000005a/0", dmem[1], rsp_valid);
    end
    repeat (3) @(negedge clk);
    run_req(1'b0, F3_LW, 32'h04, 32'h0, "lw_after_rst");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      dmem[i]    = i;
      ref_mem[i] = i;
    end
    @(negedge clk);
    test_reset();
    test_loads_stores();
    test_halfwords();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", sb_q.size());
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dmem[i] !== ref_mem[i]) begin
        failures++;
        $display("FAIL mem_final word=%0d got=%h required=%h", i, dmem[i], ref_mem[i]);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
